// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch front end.
//   word_t        : one instruction / address word
//   fetch_entry_t : a fetched instruction tagged with the PC it came from
//   PC_STEP       : byte distance between sequential instructions
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with explicit-wrap pointers, so DEPTH need
// not be a power of two.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   enq, enq_data write enq_data at the tail
//   deq           drop the head entry (caller guarantees count != 0)
//   flush         empty the buffer; overrides enq and deq
//   count         occupied entries
//   head          entry at the read pointer, all-zero when empty
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq,
  input  entry_t                     enq_data,
  input  logic                       deq,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

  entry_t mem_q [DEPTH];

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_enq, do_deq;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign do_enq = enq && !flush;
  assign do_deq = deq && !flush;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) wptr_d = ptr_inc(wptr_q);
      if (do_deq) rptr_d = ptr_inc(rptr_q);
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through head, which is gated by count.
  always_ff @(posedge CLK) begin
    if (!RST && do_enq) mem_q[wptr_q] <= enq_data;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues imem requests and
// buffers fetched instructions (tagged with their PC) so decode can stall
// independently of ihit. Supports redirect (flush + restart) and sticky halt.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   ihit, imemload           cache response for imemaddr
//   imemREN, imemaddr        fetch request toward the cache
//   redirect, redirect_pc    flush and restart fetch at redirect_pc (word aligned)
//   halt                     stop fetching; halted stays set until RST
//   deq_ready                consumer takes the head entry
//   inst_valid, inst, inst_pc head entry
//   count                    occupied entries
//   halted                   sticky halt flag
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  input  logic                       deq_ready,
  output logic                       inst_valid,
  output logic [WORD_W-1:0]          inst,
  output logic [WORD_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } q_entry_t;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              enq, deq, flush;
  q_entry_t          wr_entry, head;

  // Uses start-of-cycle count: a same-cycle dequeue does not open a slot.
  assign imemREN  = !RST && !halted_q && !redirect && (count < CntW'(DEPTH));
  assign enq      = imemREN && ihit;
  assign deq      = inst_valid && deq_ready;
  // halt arriving with redirect wins, so the flush is suppressed.
  assign flush    = redirect && !halted_q && !halt;
  assign wr_entry = '{pc: pc_q, inst: imemload};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .enq      (enq),
    .enq_data (wr_entry),
    .deq      (deq),
    .flush    (flush),
    .count    (count),
    .head     (head)
  );

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q || halt;
    if (flush) begin
      pc_d = redirect_pc & ~WORD_W'(3);
    end else if (enq) begin
      pc_d = pc_q + WORD_W'(PC_STEP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= WORD_W'(PC_INIT);
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign imemaddr   = pc_q;
  assign halted     = halted_q;
  assign inst_valid = !RST && (count != '0);
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

endmodule
